// File: rtl/axi_lite_defs_pkg.sv
// Shared definitions for the AXI4-Lite command queue: FSM state encoding,
// operation codes and default bus widths.
package axi_lite_defs_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/axi_lite_cmd_fifo.sv
// Generic synchronous FIFO: push/pop with full/empty flags and an occupancy
// count. Pushes while full and pops while empty are dropped.
module axi_lite_cmd_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_lite_cmd_queue.sv
// Command front-end for the AXI4-Lite top: buffers client commands, replays
// them one at a time as wr_en/rd_en pulses, waits for the matching done and
// returns a response over a valid/ready channel.
// Optional: define AXI_LITE_CMDQ_STATS_EN to add saturating wr_count/rd_count.
module axi_lite_cmd_queue
    import axi_lite_defs_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic [$clog2(DEPTH):0]  cmd_level,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       addr,
    output logic [DATA_W-1:0]       wdata_in,
    input  logic [DATA_W-1:0]       rdata_out,
    input  logic                    read_done,
    input  logic                    write_done
`ifdef AXI_LITE_CMDQ_STATS_EN
    ,
    output logic [15:0]             wr_count,
    output logic [15:0]             rd_count
`endif
);

    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

    state_t              state_q;
    logic                op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_en_q;
    logic                rd_en_q;
    logic                rsp_valid_q;
    logic                rsp_write_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                head_write;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_wdata;
    logic                done_match;

    axi_lite_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_write, cmd_addr, cmd_wdata}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (cmd_level)
    );

    assign {head_write, head_addr, head_wdata} = fifo_rdata;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign done_match = (op_q == OP_WRITE) ? write_done : read_done;
    assign cmd_ready  = !fifo_full;

    // Request/response sequencer; wr_en/rd_en are loaded on the IDLE->ISSUE
    // transition so the pulse lines up with the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= head_write;
                        addr_q  <= head_addr;
                        wdata_q <= head_wdata;
                        wr_en_q <= (head_write == OP_WRITE);
                        rd_en_q <= (head_write == OP_READ);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (done_match) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= op_q;
                        rsp_rdata_q <= (op_q == OP_READ) ? rdata_out : '0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wdata_in  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef AXI_LITE_CMDQ_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    // Saturating completion counters, stepped on the matching done in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            if (op_q == OP_WRITE && write_done && wr_cnt_q != 16'hFFFF)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (op_q == OP_READ && read_done && rd_cnt_q != 16'hFFFF)
                rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_queue.sv
// Self-checking bench for axi_lite_cmd_queue: directed latency/corner
// sequences, a vector table, and randomized traffic against an in-order
// reference model with a behavioural AXI top responder.
module tb_axi_lite_cmd_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [2:0]  cmd_level;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        wr_en, rd_en;
    logic [31:0] addr, wdata_in;
    logic [31:0] rdata_out = '0;
    logic        read_done, write_done;
    logic        auto_wdone = 1'b0, auto_rdone = 1'b0;
    logic        man_wdone = 1'b0, man_rdone = 1'b0;
    bit          auto_mode = 1'b0;
`ifdef AXI_LITE_CMDQ_STATS_EN
    logic [15:0] wr_count, rd_count;
`endif

    assign write_done = auto_wdone | man_wdone;
    assign read_done  = auto_rdone | man_rdone;

    axi_lite_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_level(cmd_level),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata_in(wdata_in), .rdata_out(rdata_out), .read_done(read_done),
        .write_done(write_done)
`ifdef AXI_LITE_CMDQ_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit w; logic [31:0] a; logic [31:0] d; } cmd_t;
    typedef struct { bit w; logic [31:0] d; } rsp_t;

    cmd_t        iss_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];
    int          acc_cnt = 0, iss_cnt = 0;
    bit          outstanding = 0, prev_issue = 0, prev_hold = 0;
    bit          held_write;
    logic [31:0] held_rdata;
    cmd_t        cur_cmd;
    rsp_t        exp_rsp;

    function automatic logic [31:0] mem_init(logic [31:0] a);
        return {16'hBAD0, a[15:0]};
    endfunction

    // Commands complete strictly in order, so a read returns whatever the
    // previously accepted writes left behind.
    task automatic model_accept(input bit w, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        rsp_t r;
        c.w = w; c.a = a; c.d = d;
        iss_q.push_back(c);
        r.w = w;
        if (w) begin
            model_mem[a] = d;
            r.d = '0;
        end else begin
            r.d = model_mem.exists(a) ? model_mem[a] : mem_init(a);
        end
        rsp_q.push_back(r);
        acc_cnt++;
    endtask

    // Monitor: request order, pulse width, occupancy, response order/stability.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            iss_q.delete(); rsp_q.delete();
            acc_cnt = 0; iss_cnt = 0;
            outstanding = 0; prev_issue = 0; prev_hold = 0;
        end else begin
            if (wr_en || rd_en) begin
                check("single_op", 64'(wr_en & rd_en), 0);
                check("pulse_len", 64'(prev_issue), 0);
                check("one_outstanding", 64'(outstanding), 0);
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    cur_cmd = iss_q.pop_front();
                    check("issue_op", 64'(wr_en), 64'(cur_cmd.w));
                    check("issue_addr", 64'(addr), 64'(cur_cmd.a));
                    if (cur_cmd.w) check("issue_wdata", 64'(wdata_in), 64'(cur_cmd.d));
                end
                iss_cnt++;
                outstanding = 1;
            end else if (outstanding) begin
                check("addr_stable", 64'(addr), 64'(cur_cmd.a));
            end
            prev_issue = wr_en | rd_en;
            check("level", 64'(cmd_level), 64'(acc_cnt - iss_cnt));
            check("cmd_ready", 64'(cmd_ready), 64'((acc_cnt - iss_cnt) < DEPTH));
            if (rsp_valid) begin
                check("rsp_owned", 64'(outstanding), 1);
                if (prev_hold) begin
                    check("hold_write", 64'(rsp_write), 64'(held_write));
                    check("hold_rdata", 64'(rsp_rdata), 64'(held_rdata));
                end
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        exp_rsp = rsp_q.pop_front();
                        check("rsp_write", 64'(rsp_write), 64'(exp_rsp.w));
                        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp.d));
                    end
                    outstanding = 0;
                    prev_hold = 0;
                end else begin
                    prev_hold = 1;
                    held_write = rsp_write;
                    held_rdata = rsp_rdata;
                end
            end else begin
                prev_hold = 0;
            end
            if (cmd_valid && cmd_ready) model_accept(cmd_write, cmd_addr, cmd_wdata);
        end
    end

    // Behavioural AXI top: memory plus done pulses after a random latency.
    bit          pend = 0, pend_w = 0;
    int unsigned pend_cnt = 0;
    initial forever begin
        @(negedge clk);
        auto_wdone = 1'b0;
        auto_rdone = 1'b0;
        if (reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    if (pend_w) auto_wdone = 1'b1; else auto_rdone = 1'b1;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            if (wr_en) slave_mem[addr] = wdata_in;
            if (rd_en) rdata_out = slave_mem.exists(addr) ? slave_mem[addr] : mem_init(addr);
            if ((wr_en || rd_en) && auto_mode) begin
                pend = 1;
                pend_w = wr_en;
                pend_cnt = $urandom_range(0, 4);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_issue(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (wr_en || rd_en) seen = 1; else tick();
        end
        check(name, 64'(seen), 1);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          exp_w;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'h0};
        tbl[1] = '{1'b0, 32'h20, 32'h0,         1'b0, 32'h1234_5678};
        tbl[2] = '{1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 32'h10, 32'hCAFE_F00D, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h10, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[5] = '{1'b0, 32'h44, 32'h0,         1'b0, 32'hBAD0_0044};
        tbl[6] = '{1'b1, 32'h44, 32'h0,         1'b1, 32'h0};
        tbl[7] = '{1'b0, 32'h44, 32'h0,         1'b0, 32'h0};

        // Reset values
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_cmd_ready", 64'(cmd_ready), 1);
        check("rst_cmd_level", 64'(cmd_level), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_write", 64'(rsp_write), 0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 0);
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_rd_en", 64'(rd_en), 0);
        check("rst_addr", 64'(addr), 0);
        check("rst_wdata_in", 64'(wdata_in), 0);

        // Single write on an idle queue, exact cycle latency, manual dones
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        check("lat_c1_level", 64'(cmd_level), 1);
        check("lat_c1_wr_en", 64'(wr_en), 0);
        tick();
        check("lat_c2_wr_en", 64'(wr_en), 1);
        check("lat_c2_rd_en", 64'(rd_en), 0);
        check("lat_c2_addr", 64'(addr), 32'h10);
        check("lat_c2_wdata", 64'(wdata_in), 32'hDEAD_BEEF);
        tick();
        check("lat_c3_wr_en", 64'(wr_en), 0);
        man_rdone = 1'b1;
        tick();
        man_rdone = 1'b0;
        tick();
        check("wrong_done_ignored", 64'(rsp_valid), 0);
        man_wdone = 1'b1;
        tick();
        man_wdone = 1'b0;
        check("wr_rsp_valid", 64'(rsp_valid), 1);
        check("wr_rsp_write", 64'(rsp_write), 1);
        check("wr_rsp_rdata", 64'(rsp_rdata), 0);

        // Backpressure: a queued read must not issue while the response waits
        send(1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 1);
            check("bp_no_issue", 64'(wr_en | rd_en), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_released", 64'(rsp_valid), 0);

        // Spurious write_done during a read, then both dones together
        wait_issue("rd_issue_seen");
        check("rd_issue_is_read", 64'(rd_en), 1);
        tick();
        man_wdone = 1'b1;
        tick();
        man_wdone = 1'b0;
        tick();
        check("spurious_wdone", 64'(rsp_valid), 0);
        man_wdone = 1'b1; man_rdone = 1'b1;
        tick();
        man_wdone = 1'b0; man_rdone = 1'b0;
        check("both_rsp_valid", 64'(rsp_valid), 1);
        check("both_rsp_write", 64'(rsp_write), 0);
        check("both_rsp_rdata", 64'(rsp_rdata), 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        man_rdone = 1'b1;
        tick();
        man_rdone = 1'b0;
        tick(); tick();
        check("idle_done_rsp", 64'(rsp_valid), 0);
        check("idle_done_issue", 64'(wr_en | rd_en), 0);

        // Vector table under the automatic responder
        auto_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].w, tbl[i].a, tbl[i].d);
            for (int k = 0; k < 40 && !rsp_valid; k++) tick();
            check($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 1);
            check($sformatf("tbl%0d_write", i), 64'(rsp_write), 64'(tbl[i].exp_w));
            check($sformatf("tbl%0d_rdata", i), 64'(rsp_rdata), 64'(tbl[i].exp_d));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end

        // Full queue: first command parked in RESP, four more fill the FIFO
        for (int k = 0; k < 20 && (pend || rsp_valid); k++) tick();
        auto_mode = 1'b0;
        send(1'b1, 32'h30, 32'h0000_0001);
        wait_issue("full_first_issue");
        tick();
        man_wdone = 1'b1;
        tick();
        man_wdone = 1'b0;
        check("full_first_rsp", 64'(rsp_valid), 1);
        send(1'b0, 32'h30, 32'h0);
        send(1'b1, 32'h34, 32'h0000_0002);
        send(1'b0, 32'h34, 32'h0);
        send(1'b1, 32'h30, 32'h0000_0003);
        check("full_level", 64'(cmd_level), 4);
        check("full_not_ready", 64'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold_level", 64'(cmd_level), 4);
        end
        auto_mode = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 32'h30, 32'h0);
        for (int k = 0; k < 300 && (rsp_q.size() != 0 || outstanding); k++) tick();
        check("full_drained", 64'(rsp_q.size()), 0);
        rsp_ready = 1'b0;

        // Reset while a write waits with three reads queued
        for (int k = 0; k < 20 && pend; k++) tick();
        auto_mode = 1'b0;
        send(1'b1, 32'h50, 32'h5555_AAAA);
        wait_issue("rst_seq_issue");
        send(1'b0, 32'h50, 32'h0);
        send(1'b0, 32'h10, 32'h0);
        send(1'b0, 32'h60, 32'h0);
        check("pre_rst_level", 64'(cmd_level), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_level", 64'(cmd_level), 0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        check("mid_rst_wr_en", 64'(wr_en), 0);
        check("mid_rst_rd_en", 64'(rd_en), 0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 1);
        man_wdone = 1'b1;
        tick();
        man_wdone = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_quiet", 64'(rsp_valid | wr_en | rd_en), 0);
        end

        // Randomized traffic with random backpressure
        auto_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_write = ($urandom_range(0, 1) == 1);
            cmd_addr  = 32'($urandom_range(0, 7)) * 32'd4;
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 800 && (rsp_q.size() != 0 || outstanding); k++) tick();
        check("rand_rsp_drained", 64'(rsp_q.size()), 0);
        check("rand_iss_drained", 64'(iss_q.size()), 0);
        check("rand_final_level", 64'(cmd_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_queue.md
Name: axi_lite_cmd_queue

Overview:
- Command front-end that sits directly upstream of the AXI4-Lite master/slave top.
- Buffers read/write requests from a client in a small synchronous FIFO.
- Replays each request one at a time onto the top's simple request interface (wr_en/rd_en/addr/wdata_in), waits for write_done/read_done, and returns a response (read data or write ack) over a valid/ready channel.
- Exactly one AXI transaction outstanding at any time.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- ADDR_W, 32, address width; must match top addr.
- DATA_W, 32, data width; must match top wdata_in/rdata_out.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  client command valid.
- cmd_ready  output  1  queue can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  command address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- cmd_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  client accepts response.
- rsp_write  output  1  response belongs to a write.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- wr_en  output  1  one-cycle write request pulse to top.
- rd_en  output  1  one-cycle read request pulse to top.
- addr  output  ADDR_W  request address to top.
- wdata_in  output  DATA_W  request write data to top.
- rdata_out  input  DATA_W  read data from top; valid with read_done.
- read_done  input  1  one-cycle read completion pulse from top.
- write_done  input  1  one-cycle write completion pulse from top.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: cmd_ready=1, cmd_level=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, wr_en=0, rd_en=0, addr=0, wdata_in=0. FIFO is flushed and the FSM goes to IDLE.
- FIFO push: on cmd_valid && cmd_ready, the entry {write, addr, wdata} is pushed.
- cmd_ready = !full, independent of a same-cycle pop; there is no pass-through when full.
- Simultaneous push and pop with FIFO neither full nor empty: cmd_level is unchanged.
- Pointers wrap modulo DEPTH.
- FSM state IDLE: if FIFO non-empty, pop the head into the addr/wdata_in/op registers and go to ISSUE. If empty, stay.
- FSM state ISSUE (1 cycle): assert wr_en (op=write) or rd_en (op=read) for exactly this cycle, then go to WAIT.
- FSM state WAIT: addr and wdata_in stay stable until completion.
  - Write op: completes only on write_done.
  - Read op: completes only on read_done.
  - A done for the other op type is ignored.
  - If both dones arrive in the same cycle, only the matching one is used.
  - On completion: rsp_valid<=1, rsp_write<=op, rsp_rdata<=(read ? rdata_out : 0); go to RESP.
- FSM state RESP: rsp_valid, rsp_write and rsp_rdata are held stable. On rsp_ready, clear rsp_valid and go to IDLE.
- Done pulses seen in IDLE, ISSUE or RESP are ignored.
- Minimum command-to-command spacing is 4 cycles plus the AXI latency.
- Response for a command accepted on an idle empty queue: cmd accepted cycle 0, pop cycle 1, wr_en/rd_en cycle 2, rsp_valid the cycle after done.
- Ordering: responses are returned strictly in command order.
- Reset mid-transaction: state returns to IDLE and FIFO contents are discarded. The top is reset by the same signal, so no stale done is expected; any done that does arrive is ignored in IDLE.

Optional Feature:
- Macro: AXI_LITE_CMDQ_STATS_EN.
- Defined: adds outputs wr_count[15:0] and rd_count[15:0].
  - Each increments on a completed write or read respectively (in WAIT, on the matching done).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/include axi_lite_defs:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - OP_READ=1'b0 and OP_WRITE=1'b1 constants.
  - Default ADDR_W/DATA_W.
- Sub-module axi_lite_cmd_fifo: generic synchronous FIFO with push/pop/full/empty/level, width 1+ADDR_W+DATA_W, depth DEPTH.
- The FSM and response register live in axi_lite_cmd_queue.

Test Plan:
- Single write: cmd write addr=0x10 wdata=0xDEADBEEF on an idle queue -> wr_en pulses 1 cycle with addr=0x10 and wdata_in=0xDEADBEEF; after write_done, rsp_valid=1, rsp_write=1, rsp_rdata=0.
- Write then read back: write 0x20/0x12345678, then read 0x20 -> second response rsp_write=0, rsp_rdata=0x12345678; responses arrive in order.
- Full queue: push DEPTH(4) commands with rsp_ready=0 -> cmd_ready=0 once cmd_level reaches 4 while the first transaction waits in RESP; the 5th command is accepted only after a pop.
- Backpressure: hold rsp_ready=0 for 10 cycles after the first done -> response fields stay stable, no new wr_en/rd_en is issued; releasing rsp_ready drains the remaining commands in order.
- Spurious dones: inject write_done while a read is pending, and read_done in IDLE -> no response is generated and state is unchanged; the real read_done completes normally.
- Reset mid-WAIT: assert reset for 1 cycle with 3 queued commands -> cmd_level=0, rsp_valid=0, wr_en=rd_en=0, and no response emerges afterward.
